// File: rtl/riscv_dmem_ctrl_if.sv
// Data-side bus between the RISC-V core MA stage (master) and the DMEM slave.
// Optional data_err signal exists only when RISCV_DMEM_ERR_EN is defined.
interface riscv_dmem_ctrl_if #(
    parameter int P_DATA_WIDTH      = 32,
    parameter int P_DMEM_ADDR_WIDTH = 32
);
    logic [P_DMEM_ADDR_WIDTH-1:0] data_addr;
    logic [P_DATA_WIDTH-1:0]      data_wr;
    logic                         data_wr_en_ma;
    logic                         data_rd_en_ma;
    logic [3:0]                   data_rd_en_ctrl;
    logic [P_DATA_WIDTH-1:0]      data_rd;
    logic                         data_ready;
`ifdef RISCV_DMEM_ERR_EN
    logic                         data_err;

    modport master (
        output data_addr, data_wr, data_wr_en_ma, data_rd_en_ma, data_rd_en_ctrl,
        input  data_rd, data_ready, data_err
    );
    modport slave (
        input  data_addr, data_wr, data_wr_en_ma, data_rd_en_ma, data_rd_en_ctrl,
        output data_rd, data_ready, data_err
    );
`else
    modport master (
        output data_addr, data_wr, data_wr_en_ma, data_rd_en_ma, data_rd_en_ctrl,
        input  data_rd, data_ready
    );
    modport slave (
        input  data_addr, data_wr, data_wr_en_ma, data_rd_en_ma, data_rd_en_ctrl,
        output data_rd, data_ready
    );
`endif
endinterface

// File: rtl/riscv_dmem_ctrl.sv
// Data-memory slave for the RISC-V MA stage: byte-lane reads/writes with P_WAIT_CYCLES wait states.
// Define RISCV_DMEM_ERR_EN to add data_err (out-of-range or simultaneous rd+wr request).
module riscv_dmem_ctrl #(
    parameter int P_DATA_WIDTH      = 32,
    parameter int P_DMEM_ADDR_WIDTH = 32,
    parameter int P_DEPTH_WORDS     = 1024,
    parameter int P_WAIT_CYCLES     = 2
) (
    input  logic              clk,
    input  logic              reset,
    riscv_dmem_ctrl_if.slave  bus
);
    localparam int         LP_IDX_W       = $clog2(P_DEPTH_WORDS);
    localparam logic [3:0] LP_WAIT_CYCLES = 4'(P_WAIT_CYCLES);
    localparam logic [1:0] LP_IDLE        = 2'd0;
    localparam logic [1:0] LP_WAIT        = 2'd1;
    localparam logic [1:0] LP_RESP        = 2'd2;

    // Expand a 4-bit byte-lane mask into a full-word bit mask.
    function automatic logic [P_DATA_WIDTH-1:0] lane_mask_f(input logic [3:0] mask);
        logic [P_DATA_WIDTH-1:0] bits;
        bits = {P_DATA_WIDTH{1'b0}};
        for (int i = 0; i < 4; i++) begin
            bits[8*i +: 8] = {8{mask[i]}};
        end
        return bits;
    endfunction

    logic [P_DATA_WIDTH-1:0] mem_r [P_DEPTH_WORDS];

    logic [1:0]              state_r;
    logic [3:0]              cnt_r;
    logic [LP_IDX_W-1:0]     idx_r;
    logic [P_DATA_WIDTH-1:0] wdata_r;
    logic [3:0]              mask_r;
    logic                    op_wr_r;
    logic                    in_range_r;
    logic                    err_r;
    logic [P_DATA_WIDTH-1:0] data_rd_r;
    logic                    data_ready_r;
    logic                    data_err_r;

    logic                    req_s;
    logic                    in_range_s;
    logic                    done_s;
    logic [P_DATA_WIDTH-1:0] lane_bits_s;

    // Request decode and end-of-wait detection.
    always_comb begin
        req_s       = bus.data_rd_en_ma | bus.data_wr_en_ma;
        // Any set bit above the word index means the address is beyond the array.
        in_range_s  = ((bus.data_addr >> (LP_IDX_W + 2)) == {P_DMEM_ADDR_WIDTH{1'b0}});
        done_s      = (state_r == LP_WAIT) && (cnt_r == LP_WAIT_CYCLES);
        lane_bits_s = lane_mask_f(mask_r);
    end

    // Control FSM, request capture and registered response outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= LP_IDLE;
            cnt_r        <= 4'd0;
            idx_r        <= {LP_IDX_W{1'b0}};
            wdata_r      <= {P_DATA_WIDTH{1'b0}};
            mask_r       <= 4'd0;
            op_wr_r      <= 1'b0;
            in_range_r   <= 1'b0;
            err_r        <= 1'b0;
            data_rd_r    <= {P_DATA_WIDTH{1'b0}};
            data_ready_r <= 1'b0;
            data_err_r   <= 1'b0;
        end else begin
            data_ready_r <= 1'b0;
            data_err_r   <= 1'b0;
            case (state_r)
                LP_IDLE: begin
                    if (req_s) begin
                        idx_r      <= bus.data_addr[LP_IDX_W+1:2];
                        wdata_r    <= bus.data_wr;
                        mask_r     <= bus.data_rd_en_ctrl;
                        // Write wins when both enables are high; the read is dropped.
                        op_wr_r    <= bus.data_wr_en_ma;
                        in_range_r <= in_range_s;
                        err_r      <= ~in_range_s | (bus.data_wr_en_ma & bus.data_rd_en_ma);
                        cnt_r      <= 4'd0;
                        state_r    <= LP_WAIT;
                    end
                end
                LP_WAIT: begin
                    if (done_s) begin
                        cnt_r        <= 4'd0;
                        state_r      <= LP_RESP;
                        data_ready_r <= 1'b1;
                        data_err_r   <= err_r;
                        if (!op_wr_r) begin
                            data_rd_r <= in_range_r ? (mem_r[idx_r] & lane_bits_s)
                                                    : {P_DATA_WIDTH{1'b0}};
                        end
                    end else begin
                        cnt_r <= cnt_r + 4'd1;
                    end
                end
                LP_RESP: begin
                    state_r <= LP_IDLE;
                end
                default: begin
                    state_r <= LP_IDLE;
                    cnt_r   <= 4'd0;
                end
            endcase
        end
    end

    // Byte-lane write commit on the edge entering RESP; a coincident reset cancels it.
    always_ff @(posedge clk) begin
        if (!reset && done_s && op_wr_r && in_range_r) begin
            for (int i = 0; i < 4; i++) begin
                if (mask_r[i]) begin
                    mem_r[idx_r][8*i +: 8] <= wdata_r[8*i +: 8];
                end
            end
        end
    end

    assign bus.data_rd    = data_rd_r;
    assign bus.data_ready = data_ready_r;
`ifdef RISCV_DMEM_ERR_EN
    assign bus.data_err   = data_err_r;
`endif

endmodule

// File: tb/tb_riscv_dmem_ctrl.sv
// Scoreboard bench for riscv_dmem_ctrl: directed and random traffic against a word/byte reference model.
module tb_riscv_dmem_ctrl;
    localparam int W     = 2;
    localparam int DEPTH = 1024;

    typedef struct {
        logic [31:0] rd;
        logic        err;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;

    logic [31:0] model_mem [DEPTH];
    logic [31:0] model_rd;
    exp_t        sb_q [$];
    logic        prev_ready = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    riscv_dmem_ctrl_if #(.P_DATA_WIDTH(32), .P_DMEM_ADDR_WIDTH(32)) dif ();

    riscv_dmem_ctrl #(
        .P_DATA_WIDTH(32), .P_DMEM_ADDR_WIDTH(32),
        .P_DEPTH_WORDS(DEPTH), .P_WAIT_CYCLES(W)
    ) dut (
        .clk(clk), .reset(reset), .bus(dif)
    );

    function automatic logic [31:0] lanes_of(input logic [31:0] w, input logic [3:0] m);
        logic [31:0] r = 32'd0;
        for (int i = 0; i < 4; i++)
            if (m[i]) r = r | (w & (32'hFF << (8 * i)));
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every completion pulse is matched against the oldest expected response.
    always @(negedge clk) begin
        if (reset === 1'b0 && dif.data_ready === 1'b1) begin
            exp_t e;
            check("ready_single_cycle", {31'd0, prev_ready}, 32'd0);
            if (sb_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_ready: got ready with empty scoreboard (cycle %0d)", cyc);
            end else begin
                e = sb_q.pop_front();
                check("data_rd", dif.data_rd, e.rd);
                check("latency", cyc, e.cyc);
`ifdef RISCV_DMEM_ERR_EN
                check("data_err", {31'd0, dif.data_err}, {31'd0, e.err});
`endif
            end
        end
        prev_ready <= dif.data_ready;
    end

    task automatic issue(input logic wr, input logic rd, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] mask);
        exp_t e;
        bit   in_range;
        bit   got;
        @(negedge clk);
        in_range = (addr / 32'd4) < 32'(DEPTH);
        if (wr) begin
            if (in_range)
                model_mem[addr[11:2]] = lanes_of(wdata, mask) |
                                        (model_mem[addr[11:2]] & ~lanes_of(32'hFFFF_FFFF, mask));
        end else begin
            model_rd = in_range ? lanes_of(model_mem[addr[11:2]], mask) : 32'd0;
        end
        e.rd  = model_rd;
        e.err = !in_range || (wr && rd);
        e.cyc = cyc + W + 2;
        sb_q.push_back(e);
        dif.data_addr       = addr;
        dif.data_wr         = wdata;
        dif.data_wr_en_ma   = wr;
        dif.data_rd_en_ma   = rd;
        dif.data_rd_en_ctrl = mask;
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            got = dif.data_ready;
        end
        dif.data_wr_en_ma = 1'b0;
        dif.data_rd_en_ma = 1'b0;
        n_checks++;
        if (!got) begin
            n_errors++;
            $display("FAIL ready_timeout: no ready for addr %h, expected within 40 cycles", addr);
            void'(sb_q.pop_back());
        end
    endtask

    // Reset asserted `delay` edges after capture; delay==W lands on the commit edge.
    task automatic reset_during_write(input logic [31:0] addr, input logic [31:0] wdata, input int delay);
        @(negedge clk);
        dif.data_addr       = addr;
        dif.data_wr         = wdata;
        dif.data_wr_en_ma   = 1'b1;
        dif.data_rd_en_ma   = 1'b0;
        dif.data_rd_en_ctrl = 4'hF;
        @(posedge clk);
        repeat (delay) @(posedge clk);
        @(negedge clk);
        reset             = 1'b1;
        dif.data_wr_en_ma = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        check("abort_ready", {31'd0, dif.data_ready}, 32'd0);
        check("abort_rd", dif.data_rd, 32'd0);
        model_rd = 32'd0;
        repeat (W + 4) @(negedge clk);
    endtask

    initial begin
        logic [31:0] a;
        int          r;
        reset               = 1'b1;
        dif.data_addr       = 32'd0;
        dif.data_wr         = 32'd0;
        dif.data_wr_en_ma   = 1'b0;
        dif.data_rd_en_ma   = 1'b0;
        dif.data_rd_en_ctrl = 4'd0;
        model_rd            = 32'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check("reset_ready", {31'd0, dif.data_ready}, 32'd0);
        check("reset_rd", dif.data_rd, 32'd0);

        for (int i = 0; i < DEPTH; i++) issue(1'b1, 1'b0, 32'(i * 4), $urandom, 4'hF);

        issue(1'b1, 1'b0, 32'h10, 32'hDEAD_BEEF, 4'hF);
        issue(1'b0, 1'b1, 32'h10, 32'd0, 4'hF);
        issue(1'b1, 1'b0, 32'h20, 32'h1122_3344, 4'hF);
        issue(1'b1, 1'b0, 32'h20, 32'hAABB_CCDD, 4'b0101);
        issue(1'b0, 1'b1, 32'h20, 32'd0, 4'hF);
        issue(1'b0, 1'b1, 32'h20, 32'd0, 4'b0010);
        issue(1'b0, 1'b1, 32'h23, 32'd0, 4'b1001);
        issue(1'b0, 1'b1, 32'h20, 32'd0, 4'b0000);
        issue(1'b1, 1'b0, 32'h20, 32'hFFFF_FFFF, 4'b0000);
        issue(1'b0, 1'b1, 32'h20, 32'd0, 4'hF);
        issue(1'b0, 1'b1, 32'h1000, 32'd0, 4'hF);
        issue(1'b1, 1'b0, 32'h1000, 32'h5555_AAAA, 4'hF);
        issue(1'b0, 1'b1, 32'h0, 32'd0, 4'hF);
        issue(1'b0, 1'b1, 32'h8000_0000, 32'd0, 4'hF);
        issue(1'b1, 1'b0, 32'hFFC, 32'h0BAD_F00D, 4'hF);
        issue(1'b0, 1'b1, 32'hFFC, 32'd0, 4'hF);
        issue(1'b0, 1'b1, 32'h10, 32'd0, 4'hF);
        issue(1'b1, 1'b1, 32'h30, 32'h5, 4'hF);
        issue(1'b0, 1'b1, 32'h30, 32'd0, 4'hF);

        issue(1'b1, 1'b0, 32'h40, 32'h1234_5678, 4'hF);
        reset_during_write(32'h40, 32'hCAFE_F00D, 0);
        issue(1'b0, 1'b1, 32'h40, 32'd0, 4'hF);
        reset_during_write(32'h40, 32'hCAFE_F00D, W);
        issue(1'b0, 1'b1, 32'h40, 32'd0, 4'hF);

        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 7) == 0) a = $urandom | 32'h0000_1000;
            else a = {20'd0, 10'($urandom_range(0, DEPTH - 1)), 2'($urandom_range(0, 3))};
            r = $urandom_range(0, 9);
            if (r == 0)      issue(1'b1, 1'b1, a, $urandom, 4'($urandom_range(0, 15)));
            else if (r < 5)  issue(1'b1, 1'b0, a, $urandom, 4'($urandom_range(0, 15)));
            else             issue(1'b0, 1'b1, a, 32'd0, 4'($urandom_range(0, 15)));
        end

        repeat (W + 4) @(negedge clk);
        check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
